// File: rtl/vram_arbiter_pkg.sv
// Shared constants and types for the VRAM arbiter slice.
// Holds the 640x480 timing geometry, the 4x4-scaled frame-buffer size and
// address width, the RGB 3:3:2 pixel type and the arbiter FSM state encoding.
package vram_arbiter_pkg;

  localparam int unsigned H_ACTIVE   = 640;
  localparam int unsigned V_ACTIVE   = 480;
  localparam int unsigned SCALE_LOG2 = 2;
  localparam int unsigned CNT_W      = 10;
  localparam int unsigned FB_W       = H_ACTIVE >> SCALE_LOG2;
  localparam int unsigned FB_H       = V_ACTIVE >> SCALE_LOG2;
  localparam int unsigned FB_SIZE    = FB_W * FB_H;
  localparam int unsigned FB_ADDR_W  = 15;
  localparam int unsigned DATA_W     = 8;

  // One stored pixel, RGB 3:3:2.
  typedef struct packed {
    logic [2:0] r;
    logic [2:0] g;
    logic [1:0] b;
  } pixel_t;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_FETCH   = 2'd1,
    ST_CAPTURE = 2'd2
  } state_e;

endpackage

// File: rtl/vram_arbiter_if.sv
// Bus bundle between the arbiter and its neighbours.
// slave  : arbiter side (timing + writer request + RAM read data in; RAM control,
//          writer ready, colour and error flag out).
// master : timing generator / pixel writer / RAM side, the mirror image.
interface vram_arbiter_if;
  import vram_arbiter_pkg::*;

  logic                 pix_en;
  logic [CNT_W-1:0]     h;
  logic [CNT_W-1:0]     v;
  logic                 wr_valid;
  logic                 wr_ready;
  logic [FB_ADDR_W-1:0] wr_addr;
  pixel_t               wr_data;
  logic [FB_ADDR_W-1:0] mem_addr;
  logic                 mem_we;
  pixel_t               mem_wdata;
  pixel_t               mem_rdata;
  pixel_t               pix_data;
  logic                 wr_err;

  modport slave (
    input  pix_en, h, v, wr_valid, wr_addr, wr_data, mem_rdata,
    output wr_ready, mem_addr, mem_we, mem_wdata, pix_data, wr_err
  );

  modport master (
    output pix_en, h, v, wr_valid, wr_addr, wr_data, mem_rdata,
    input  wr_ready, mem_addr, mem_we, mem_wdata, pix_data, wr_err
  );

endinterface

// File: rtl/vram_addr_gen.sv
// Maps the scan position (h,v) to a linear frame-buffer address and an active flag.
// Ports: h_i, v_i   scan counters
//        addr_o     (v>>2)*FB_W + (h>>2), FB_ADDR_W wide
//        active_o   h<640 && v<480
module vram_addr_gen
  import vram_arbiter_pkg::*;
(
  input  logic [CNT_W-1:0]     h_i,
  input  logic [CNT_W-1:0]     v_i,
  output logic [FB_ADDR_W-1:0] addr_o,
  output logic                 active_o
);

  localparam int unsigned CW = CNT_W - SCALE_LOG2;

  logic [CW-1:0] hx;
  logic [CW-1:0] vy;

  assign hx = h_i[CNT_W-1:SCALE_LOG2];
  assign vy = v_i[CNT_W-1:SCALE_LOG2];

  // FB_W = 160 = 128 + 32, so the row multiply is two shifted copies of vy.
  // Inside the active area the sum peaks at 19199, well within FB_ADDR_W bits.
  assign addr_o = FB_ADDR_W'({vy, 7'b0}) + FB_ADDR_W'({vy, 5'b0}) + FB_ADDR_W'(hx);

  assign active_o = (h_i < CNT_W'(H_ACTIVE)) && (v_i < CNT_W'(V_ACTIVE));

endmodule

// File: rtl/vram_arbiter.sv
// Arbitrates one single-port synchronous frame-buffer RAM between VGA scan-out
// (absolute priority) and a pixel writer; each stored pixel covers 4x4 screen pixels.
// Ports: clk, clr (async active-high reset), bus (vram_arbiter_if.slave):
//   pix_en/h/v from the timing generator, wr_valid/wr_ready/wr_addr/wr_data writer
//   handshake, mem_addr/mem_we/mem_wdata/mem_rdata RAM port, pix_data colour out,
//   wr_err sticky out-of-range flag.
// Build option: VRAM_VBLANK_WR_EN restricts writer transfers to vertical blanking.
module vram_arbiter
  import vram_arbiter_pkg::*;
(
  input logic           clk,
  input logic           clr,
  vram_arbiter_if.slave bus
);

  logic [FB_ADDR_W-1:0] disp_addr;
  logic                 active;
  logic                 fetch_req;
  logic                 wr_window;
  logic                 wr_ready_c;
  logic                 xfer;
  logic                 in_range;

  state_e state_q, state_d;
  pixel_t pix_data_q, pix_data_d;
  logic   wr_err_q, wr_err_d;

  vram_addr_gen u_addr_gen (
    .h_i      (bus.h),
    .v_i      (bus.v),
    .addr_o   (disp_addr),
    .active_o (active)
  );

  // One fetch per group of four replicated pixels.
  assign fetch_req = bus.pix_en && active && (bus.h[SCALE_LOG2-1:0] == '0);

`ifdef VRAM_VBLANK_WR_EN
  assign wr_window = (bus.v >= CNT_W'(V_ACTIVE));
`else
  assign wr_window = 1'b1;
`endif

  // Writer owns the port whenever the display is not addressing it or awaiting data.
  assign wr_ready_c = !clr && !fetch_req && (state_q != ST_FETCH) && wr_window;
  assign xfer       = bus.wr_valid && wr_ready_c;
  assign in_range   = bus.wr_addr < FB_ADDR_W'(FB_SIZE);

  assign bus.wr_ready = wr_ready_c;
  assign bus.pix_data = pix_data_q;
  assign bus.wr_err   = wr_err_q;

  // Next state, colour capture and RAM port mux.
  always_comb begin
    state_d       = state_q;
    pix_data_d    = pix_data_q;
    wr_err_d      = wr_err_q;
    bus.mem_addr  = '0;
    bus.mem_we    = 1'b0;
    bus.mem_wdata = '0;

    unique case (state_q)
      ST_IDLE: begin
        if (fetch_req) state_d = ST_FETCH;
      end
      // RAM data is valid now; it is registered on the edge leaving FETCH so the
      // colour is visible during CAPTURE, two cycles after the request.
      ST_FETCH: begin
        pix_data_d = bus.mem_rdata;
        state_d    = ST_CAPTURE;
      end
      ST_CAPTURE: begin
        state_d = fetch_req ? ST_FETCH : ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    // Blank output outside the active area.
    if (bus.pix_en && !active) pix_data_d = '0;

    if (fetch_req && !clr) begin
      bus.mem_addr = disp_addr;
    end else if (xfer) begin
      bus.mem_addr  = bus.wr_addr;
      bus.mem_wdata = bus.wr_data;
      bus.mem_we    = in_range;
      if (!in_range) wr_err_d = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      state_q    <= ST_IDLE;
      pix_data_q <= '0;
      wr_err_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      pix_data_q <= pix_data_d;
      wr_err_q   <= wr_err_d;
    end
  end

endmodule
